mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 8:1 multiplexer among 8 requesters.

---
 rtl/mux_rr_arbiter_if.sv | 24 ++
 rtl/mux_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter
// that drives the shared 8:1 mux select.
interface mux_rr_arbiter_if;
  logic [7:0] req;    // level request per requester, held for the burst
  logic [7:0] grant;  // one-hot grant, zero when idle
  logic [2:0] sel;    // mux select = index of the granted requester
  logic       busy;   // high while any grant is active

  // Requester side: raises requests, observes grant/select.
  modport master (
    output req,
    input  grant,
    input  sel,
    input  busy
  );

  // Arbiter side: consumes requests, owns grant/select.
  modport slave (
    input  req,
    output grant,
    output sel,
    output busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a shared 8:1 mux. Picks one of eight
// requesters, drives a registered one-hot grant plus the 3-bit mux select,
// and holds the grant for the length of the requester's burst.
// Optional feature: define MUX_ARB_TIMEOUT_EN to cap each burst at MAX_HOLD
// grant cycles; without it a grant lasts until its request drops.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,  // grant cycles per burst before forced handoff
  parameter int CNT_W    = 3,  // hold counter width, 2**CNT_W >= MAX_HOLD
  parameter int PTR_INIT = 0   // top-priority requester after reset
) (
  input logic              clk,
  input logic              rst_n,
  mux_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Reject parameter sets the hold counter or pointer cannot represent.
  if (MAX_HOLD < 1 || MAX_HOLD > 8 || (2 ** CNT_W) < MAX_HOLD ||
      PTR_INIT < 0 || PTR_INIT > 7) begin : g_param_check
    $error("mux_rr_arbiter: illegal MAX_HOLD/CNT_W/PTR_INIT combination");
  end

  state_t     state_reg, state_next;
  logic [7:0] grant_reg, grant_next;
  logic [2:0] sel_reg,   sel_next;
  logic       busy_reg,  busy_next;
  logic [2:0] ptr_reg,   ptr_next;

  logic [7:0] search_req;
  logic [7:0] rot_req;
  logic       found;
  logic [2:0] offset;
  logic [2:0] winner;
  logic [7:0] winner_onehot;
  logic       req_cur;
  logic       timeout;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  assign timeout = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  // While a grant is active the current holder never competes in the search:
  // on a drop its request is already low, on a timeout it must be skipped.
  assign search_req = (state_reg == GRANT) ? (bus.req & ~grant_reg) : bus.req;
  assign req_cur    = bus.req[sel_reg];

  // Rotate the candidates so bit 0 is the highest-priority index (ptr);
  // 3-bit addition gives the mod-8 wrap for free.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rotate
    assign rot_req[gi] = search_req[ptr_reg + 3'(gi)];
  end

  // Lowest set bit of the rotated vector is the winner's distance from ptr.
  always_comb begin
    offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) offset = 3'(i);
    end
  end

  assign found         = |rot_req;
  assign winner        = ptr_reg + offset;
  assign winner_onehot = 8'd1 << winner;

  // Next-state and output decode; every register defaults to holding.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    busy_next  = busy_reg;
    ptr_next   = ptr_reg;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_cnt_next = hold_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          grant_next = winner_onehot;
          sel_next   = winner;
          busy_next  = 1'b1;
          ptr_next   = winner + 3'd1;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_next = '0;
`endif
        end
      end
      GRANT: begin
        if (req_cur && !timeout) begin
          // Burst continues; late arrivals never preempt it.
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_next = hold_cnt_reg + 1'b1;
`endif
        end else if (found) begin
          // Back-to-back handoff on the same edge, no idle bubble.
          grant_next = winner_onehot;
          sel_next   = winner;
          ptr_next   = winner + 3'd1;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_next = '0;
`endif
        end else if (req_cur) begin
          // Timed out with nobody else waiting: re-grant the same holder.
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_next = '0;
`endif
        end else begin
          // Holder dropped and nobody else wants the mux; sel keeps its value.
          state_next = IDLE;
          grant_next = 8'h00;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 8'h00;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= 8'h00;
      sel_reg   <= 3'd0;
      busy_reg  <= 1'b0;
      ptr_reg   <= 3'(PTR_INIT);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
      ptr_reg   <= ptr_next;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Counts grant cycles within the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_reg <= '0;
    else        hold_cnt_reg <= hold_cnt_next;
  end
`endif

  assign bus.grant = grant_reg;
  assign bus.sel   = sel_reg;
  assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (PTR_INIT=0, MAX_HOLD=4): a vector table
// of per-cycle expectations plus hand-written reset and burst-length sequences.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mux_rr_arbiter_if bif ();

  mux_rr_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (3),
    .PTR_INIT (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] exp_grant;
    logic [2:0] exp_sel;
    logic       exp_busy;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [0:NV-1];

  task automatic check(input string name, input logic [7:0] eg,
                       input logic [2:0] es, input logic eb);
    n_tests++;
    if (bif.grant !== eg || bif.sel !== es || bif.busy !== eb) begin
      n_fail++;
      $display("FAIL %s: got grant=%h sel=%0d busy=%b, want grant=%h sel=%0d busy=%b",
               name, bif.grant, bif.sel, bif.busy, eg, es, eb);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic r, input logic [7:0] q);
    @(negedge clk);
    rst_n   = r;
    bif.req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bif.req = 8'h00;

    // reset, rotation, wrap/skip, priority, no-preempt, mid-burst reset
    vecs[0]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1};
    vecs[2]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1};
    vecs[3]  = '{1'b1, 8'hFE, 8'h02, 3'd1, 1'b1};
    vecs[4]  = '{1'b1, 8'hFE, 8'h02, 3'd1, 1'b1};
    vecs[5]  = '{1'b1, 8'hFC, 8'h04, 3'd2, 1'b1};
    vecs[6]  = '{1'b1, 8'hFC, 8'h04, 3'd2, 1'b1};
    vecs[7]  = '{1'b1, 8'hF8, 8'h08, 3'd3, 1'b1};
    vecs[8]  = '{1'b1, 8'hF8, 8'h08, 3'd3, 1'b1};
    vecs[9]  = '{1'b1, 8'hF0, 8'h10, 3'd4, 1'b1};
    vecs[10] = '{1'b1, 8'hF0, 8'h10, 3'd4, 1'b1};
    vecs[11] = '{1'b1, 8'hE0, 8'h20, 3'd5, 1'b1};
    vecs[12] = '{1'b1, 8'hE0, 8'h20, 3'd5, 1'b1};
    vecs[13] = '{1'b1, 8'hC0, 8'h40, 3'd6, 1'b1};
    vecs[14] = '{1'b1, 8'hC0, 8'h40, 3'd6, 1'b1};
    vecs[15] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1};
    vecs[16] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1};
    vecs[17] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1};
    vecs[18] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1};
    vecs[19] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
    vecs[20] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1};
    vecs[21] = '{1'b1, 8'h00, 8'h00, 3'd2, 1'b0};
    vecs[22] = '{1'b1, 8'h84, 8'h80, 3'd7, 1'b1};
    vecs[23] = '{1'b1, 8'h84, 8'h80, 3'd7, 1'b1};
    vecs[24] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1};
    vecs[25] = '{1'b1, 8'h00, 8'h00, 3'd2, 1'b0};
    vecs[26] = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1};
    vecs[27] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1};
    vecs[28] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
    vecs[29] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b1};
    vecs[30] = '{1'b1, 8'h30, 8'h10, 3'd4, 1'b1};
    vecs[31] = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
    vecs[32] = '{1'b0, 8'h20, 8'h00, 3'd0, 1'b0};
    vecs[33] = '{1'b1, 8'hA0, 8'h20, 3'd5, 1'b1};
    vecs[34] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1};
    vecs[35] = '{1'b1, 8'h00, 8'h00, 3'd7, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst_n, vecs[i].req);
      $display("[TB] vec %0d rst_n=%b req=%h -> grant=%h sel=%0d busy=%b",
               i, vecs[i].rst_n, vecs[i].req, bif.grant, bif.sel, bif.busy);
      check($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_sel,
            vecs[i].exp_busy);
    end

    // Asynchronous reset in the middle of a burst clears outputs before any edge.
    do_reset();
    step(1'b1, 8'h20);
    check("t6_grant5", 8'h20, 3'd5, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-burst -> grant=%h sel=%0d busy=%b",
             bif.grant, bif.sel, bif.busy);
    check("t6_async_clear", 8'h00, 3'd0, 1'b0);
    step(1'b1, 8'h20);
    check("t6_regrant", 8'h20, 3'd5, 1'b1);

`ifdef MUX_ARB_TIMEOUT_EN
    // Two persistent requesters alternate every MAX_HOLD cycles.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      logic [2:0] es;
      es = ((i / 4) % 2 == 0) ? 3'd0 : 3'd1;
      step(1'b1, 8'h03);
      $display("[TB] t4 cycle %0d req=03 -> grant=%h sel=%0d", i, bif.grant, bif.sel);
      check($sformatf("t4_pair%0d", i), 8'd1 << es, es, 1'b1);
    end
    // A lone requester is re-granted on timeout without a bubble.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h10);
      $display("[TB] t4 lone cycle %0d req=10 -> grant=%h sel=%0d", i, bif.grant, bif.sel);
      check($sformatf("t4_lone%0d", i), 8'h10, 3'd4, 1'b1);
    end
`else
    // Without a timeout the first holder keeps the mux for as long as it asks.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h03);
      $display("[TB] t5 cycle %0d req=03 -> grant=%h sel=%0d", i, bif.grant, bif.sel);
      check($sformatf("t5_hold%0d", i), 8'h01, 3'd0, 1'b1);
    end
`endif
    step(1'b1, 8'h00);
    check("final_idle", 8'h00, bif.sel, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
